// File: rtl/riscv_pkg.sv
// ============================================================
// riscv_pkg : shared load/store encodings and LSU FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SH = 2'd1,
    ST_SW = 2'd2
  } store_src_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } load_src_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================
// lsu_align : byte-lane steering, load extension, access checks
// Rev 1.0
// ============================================================
`default_nettype none

module lsu_align
  import riscv_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  store_src,
  input  logic [2:0]  load_src,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    illegal     = 1'b0;
    misaligned  = 1'b0;
    if (is_store) begin
      case (store_src)
        ST_SB: begin
          be          = 4'b0001 << addr_lo;
          wdata_lanes = {4{wdata[7:0]}};
        end
        ST_SH: begin
          be          = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
          misaligned  = addr_lo[0];
        end
        ST_SW: misaligned = |addr_lo;
        default: begin
          be      = 4'b0000;
          illegal = 1'b1;
        end
      endcase
    end else begin
      case (load_src)
        LD_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
        LD_LBU:  rdata_ext = {24'd0, byte_sel};
        LD_LH: begin
          rdata_ext  = {{16{half_sel[15]}}, half_sel};
          misaligned = addr_lo[0];
        end
        LD_LHU: begin
          rdata_ext  = {16'd0, half_sel};
          misaligned = addr_lo[0];
        end
        LD_LW:   misaligned = |addr_lo;
        default: illegal = 1'b1;
      endcase
    end
    err = illegal | misaligned;
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================
// load_store_unit : single-outstanding RV32 load/store unit
// Rev 1.0
// ============================================================
`default_nettype none

module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_write,
  input  logic [1:0]        store_src,
  input  logic [2:0]        load_src,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state;
  lsu_state_e        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic [1:0]        st_q;
  logic [2:0]        ld_q;
  logic              err_q;

  logic              idle;
  logic              accept;
  logic              capture;
  logic              in_req;
  logic [1:0]        al_addr_lo;
  logic              al_we;
  logic [1:0]        al_st;
  logic [2:0]        al_ld;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_err;

  assign idle    = (state == S_IDLE);
  assign accept  = idle && req_valid;
  assign capture = mem_rvalid && !we_q &&
                   (((state == S_REQ) && mem_gnt) || (state == S_WAIT_R));

  // In IDLE the checker sees the live request so errors are known at acceptance.
  assign al_addr_lo = idle ? addr[1:0] : addr_q[1:0];
  assign al_we      = idle ? mem_write : we_q;
  assign al_st      = idle ? store_src : st_q;
  assign al_ld      = idle ? load_src  : ld_q;

  lsu_align u_align (
    .is_store    (al_we),
    .addr_lo     (al_addr_lo),
    .store_src   (al_st),
    .load_src    (al_ld),
    .wdata       (wdata_q),
    .rdata       (rdata_q),
    .be          (al_be),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata),
    .err         (al_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      st_q    <= 2'd0;
      ld_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= mem_write;
        st_q    <= store_src;
        ld_q    <= load_src;
        err_q   <= al_err;
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = al_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_nxt = (we_q || mem_rvalid) ? S_RESP : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are also forced to their idle values while reset is asserted.
  assign in_req    = (state == S_REQ) && !reset;
  assign req_ready = idle || reset;
  assign mem_req   = in_req;
  assign mem_we    = in_req && we_q;
  assign mem_be    = in_req ? al_be : 4'b0000;
  assign mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = in_req ? al_wdata : 32'd0;

  assign rsp_valid = (state == S_RESP) && !reset;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? al_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================
// tb_load_store_unit : self-checking bench for load_store_unit
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  store_src = 2'd0;
  logic [2:0]  load_src = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;

  // observations from the last run_op
  int          obs_cycle, obs_req_cycles;
  logic        obs_acc_ready, obs_err, obs_m_we, obs_unstable, obs_early_ready, obs_ready_after;
  logic [31:0] obs_rdata, obs_m_addr, obs_m_wdata;
  logic [3:0]  obs_m_be;

  // reference model results
  logic        exp_err;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata, exp_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_write  (mem_write),
    .store_src  (store_src),
    .load_src   (load_src),
    .addr       (addr),
    .wdata      (wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Access size/signedness derived from the ISA rules, then plain shift/mask arithmetic.
  task automatic ref_model(input logic we, input logic [1:0] st, input logic [2:0] ld,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md);
    int     size;
    int     off;
    bit     sgn;
    bit     legal;
    longint v;
    off = int'(a % 4); size = 4; sgn = 0; legal = 1;
    if (we) begin
      if (st == 2'd3) legal = 0; else size = 1 << st;
    end else begin
      case (ld)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: legal = 0;
      endcase
    end
    exp_err = !legal || (off % size != 0);
    exp_be = 4'd0; exp_wdata = 32'd0; exp_rdata = 32'd0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (i >= off && i < off + size) exp_be[i] = 1'b1;
          exp_wdata[8*i +: 8] = 8'(wd >> (8 * (i % size)));
        end
      end else begin
        exp_be = 4'hF;
        v = longint'(md >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        exp_rdata = v[31:0];
      end
    end
  endtask

  // Called just after a negedge; issues one request and plays the memory side.
  // Grant comes on the (gd+1)th mem_req cycle, load data rd cycles after the grant.
  task automatic run_op(input logic we, input logic [1:0] st, input logic [2:0] ld,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                        input int gd, input int rd);
    int c;
    int gnt_c;
    bit done;
    c = 1; gnt_c = 0; done = 0;
    obs_cycle = -1; obs_req_cycles = 0; obs_unstable = 0; obs_early_ready = 0;
    obs_ready_after = 0; obs_err = 1'bx; obs_rdata = 'x;
    obs_m_addr = 'x; obs_m_be = 'x; obs_m_we = 1'bx; obs_m_wdata = 'x;
    obs_acc_ready = req_ready;
    req_valid = 1'b1; mem_write = we; store_src = st; load_src = ld; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    while (!done && c < 30) begin
      @(negedge clk); c++;
      if (c == 2) begin
        req_valid = 1'b0; mem_write = 1'($urandom); store_src = 2'($urandom);
        load_src = 3'($urandom); addr = $urandom; wdata = $urandom;
      end
      if (rsp_valid) begin
        obs_cycle = c; obs_rdata = rsp_rdata; obs_err = rsp_err;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; done = 1;
      end else begin
        if (req_ready) obs_early_ready = 1'b1;
        if (mem_req) begin
          if (obs_req_cycles == 0) begin
            obs_m_addr = mem_addr; obs_m_be = mem_be; obs_m_we = mem_we; obs_m_wdata = mem_wdata;
          end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {obs_m_addr, obs_m_be, obs_m_we, obs_m_wdata}) begin
            obs_unstable = 1'b1;
          end
          obs_req_cycles++;
          mem_gnt = (obs_req_cycles == gd + 1);
          if (mem_gnt) gnt_c = c;
        end else begin
          mem_gnt = 1'b0;
        end
        mem_rvalid = (!we && gnt_c != 0 && c == gnt_c + rd);
        mem_rdata = mem_rvalid ? md : $urandom;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (done) begin
      @(negedge clk);
      obs_ready_after = req_ready;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, rsp_valid, rsp_err, mem_req, mem_we});
    end
    vectors++;
    if ({rsp_rdata, mem_be, mem_addr, mem_wdata} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h be=%h addr=%h wdata=%h expected all zero", rsp_rdata, mem_be, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b expected 100", {req_ready, rsp_valid, mem_req});
    end
  endtask

  task automatic test_sw;
    run_op(1'b1, 2'd2, 3'd0, 32'h104, 32'hDEADBEEF, 32'd0, 0, 0);
    vectors++;
    if ({obs_m_addr, obs_m_be, obs_m_we, obs_m_wdata} !== {32'h104, 4'hF, 1'b1, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL sw_mem: got addr=%h be=%b we=%b wdata=%h expected 104/1111/1/deadbeef", obs_m_addr, obs_m_be, obs_m_we, obs_m_wdata);
    end
    vectors++;
    if (obs_cycle !== 3 || obs_err !== 1'b0 || obs_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL sw_rsp: got cycle=%0d err=%b rdata=%h expected 3/0/0", obs_cycle, obs_err, obs_rdata);
    end
  endtask

  task automatic test_sb;
    run_op(1'b1, 2'd0, 3'd0, 32'h103, 32'h000000A5, 32'd0, 0, 0);
    vectors++;
    if ({obs_m_addr, obs_m_be, obs_m_wdata} !== {32'h100, 4'b1000, 32'hA5A5A5A5}) begin
      miscompares++;
      $display("FAIL sb_mem: got addr=%h be=%b wdata=%h expected 100/1000/a5a5a5a5", obs_m_addr, obs_m_be, obs_m_wdata);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  lds [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] res [3] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 2'd0, lds[i], 32'h202, 32'd0, 32'h80FF7F01, 0, 1);
      vectors++;
      if (obs_rdata !== res[i] || obs_err !== 1'b0 || obs_cycle !== 4) begin
        miscompares++;
        $display("FAIL load_ext[%0d]: got rdata=%h err=%b cycle=%0d expected %h/0/4", i, obs_rdata, obs_err, obs_cycle, res[i]);
      end
      vectors++;
      if ({obs_m_addr, obs_m_be, obs_m_we} !== {32'h200, 4'hF, 1'b0}) begin
        miscompares++;
        $display("FAIL load_mem[%0d]: got addr=%h be=%b we=%b expected 200/1111/0", i, obs_m_addr, obs_m_be, obs_m_we);
      end
    end
  endtask

  task automatic test_misaligned;
    run_op(1'b0, 2'd0, 3'd2, 32'h301, 32'd0, 32'h11223344, 0, 1);
    vectors++;
    if (obs_err !== 1'b1 || obs_cycle !== 2 || obs_req_cycles !== 0 || obs_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL lw_misaligned: got err=%b cycle=%0d req_cycles=%0d rdata=%h expected 1/2/0/0", obs_err, obs_cycle, obs_req_cycles, obs_rdata);
    end
    run_op(1'b1, 2'd1, 3'd0, 32'h105, 32'h1234, 32'd0, 0, 0);
    vectors++;
    if (obs_err !== 1'b1 || obs_cycle !== 2 || obs_req_cycles !== 0) begin
      miscompares++;
      $display("FAIL sh_misaligned: got err=%b cycle=%0d req_cycles=%0d expected 1/2/0", obs_err, obs_cycle, obs_req_cycles);
    end
  endtask

  task automatic test_stalls;
    run_op(1'b0, 2'd0, 3'd2, 32'h400, 32'd0, 32'hCAFEF00D, 3, 2);
    vectors++;
    if (obs_unstable !== 1'b0 || obs_req_cycles !== 4) begin
      miscompares++;
      $display("FAIL stall_mem: got unstable=%b req_cycles=%0d expected 0/4", obs_unstable, obs_req_cycles);
    end
    vectors++;
    if (obs_early_ready !== 1'b0 || obs_ready_after !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_ready: got early=%b after=%b expected 0/1", obs_early_ready, obs_ready_after);
    end
    vectors++;
    if (obs_cycle !== 8 || obs_rdata !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL stall_rsp: got cycle=%0d rdata=%h expected 8/cafef00d", obs_cycle, obs_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    logic rdy;
    req_valid = 1'b1; mem_write = 1'b0; load_src = 3'd2; addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_req: got mem_req=%b expected 1", mem_req);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_waitr: got ready/valid=%b expected 00", {req_ready, rsp_valid});
    end
    reset = 1'b1;
    @(negedge clk);
    seen = rsp_valid;
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    seen = seen | rsp_valid;
    mem_rvalid = 1'b0;
    @(negedge clk);
    seen = seen | rsp_valid;
    rdy = req_ready;
    vectors++;
    if (seen !== 1'b0 || rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_abandon: got rsp_seen=%b ready=%b expected 0/1", seen, rdy);
    end
  endtask

  task automatic test_back_to_back;
    run_op(1'b1, 2'd1, 3'd0, 32'h012, 32'h0000BEEF, 32'd0, 0, 0);
    vectors++;
    if (obs_ready_after !== 1'b1 || obs_m_be !== 4'b1100 || obs_m_wdata !== 32'hBEEFBEEF) begin
      miscompares++;
      $display("FAIL b2b_first: got ready=%b be=%b wdata=%h expected 1/1100/beefbeef", obs_ready_after, obs_m_be, obs_m_wdata);
    end
    run_op(1'b0, 2'd0, 3'd5, 32'h012, 32'd0, 32'h9ABC5678, 0, 1);
    vectors++;
    if (obs_acc_ready !== 1'b1 || obs_cycle !== 4 || obs_rdata !== 32'h00009ABC) begin
      miscompares++;
      $display("FAIL b2b_second: got ready=%b cycle=%0d rdata=%h expected 1/4/00009abc", obs_acc_ready, obs_cycle, obs_rdata);
    end
  endtask

  task automatic test_random;
    logic        we;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] a, wd, md;
    int          gd, rd, exp_cycle;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom); st = 2'($urandom); ld = 3'($urandom);
      a = $urandom; wd = $urandom; md = $urandom;
      gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      ref_model(we, st, ld, a, wd, md);
      exp_cycle = exp_err ? 2 : (we ? 3 + gd : 3 + gd + rd);
      run_op(we, st, ld, a, wd, md, gd, rd);
      vectors++;
      if (obs_cycle !== exp_cycle || obs_err !== exp_err || obs_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d]: got cycle=%0d err=%b rdata=%h expected %0d/%b/%h", n, obs_cycle, obs_err, obs_rdata, exp_cycle, exp_err, exp_rdata);
      end
      vectors++;
      if (obs_req_cycles !== (exp_err ? 0 : gd + 1) || obs_ready_after !== 1'b1 || obs_early_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_proto[%0d]: got req_cycles=%0d ready_after=%b early=%b expected %0d/1/0", n, obs_req_cycles, obs_ready_after, obs_early_ready, exp_err ? 0 : gd + 1);
      end
      if (!exp_err) begin
        vectors++;
        if (obs_m_addr !== {a[31:2], 2'b00} || obs_m_be !== exp_be || obs_m_we !== we || obs_unstable !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_mem[%0d]: got addr=%h be=%b we=%b unstable=%b expected %h/%b/%b/0", n, obs_m_addr, obs_m_be, obs_m_we, obs_unstable, {a[31:2], 2'b00}, exp_be, we);
        end
        if (we) begin
          vectors++;
          if (obs_m_wdata !== exp_wdata) begin
            miscompares++;
            $display("FAIL rand_wdata[%0d]: got %h expected %h", n, obs_m_wdata, exp_wdata);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_sb;
    test_loads;
    test_misaligned;
    test_stalls;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
